cdb_arbiter: RTL and testbench

Arbitrates the single common data bus (tag_renew/data_renew) that feeds the reservation station, the load-store buffer and the ROB.
- Two producers compete for the bus: the ALU result path and the load-store buffer result path.
- Each producer has a small FIFO, so a losing producer does not lose its result.
- Ties are broken round-robin, and one result is broadcast per cycle.

---
 rtl/cdb_arbiter_pkg.sv | 17 +
 rtl/cdb_arbiter_if.sv | 38 +++
 rtl/cdb_arbiter_fifo.sv | 48 ++++
 rtl/cdb_arbiter.sv | 93 +++++++++
 tb/tb_cdb_arbiter.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared widths, idle encodings and grant encoding for the common data bus arbiter.
// The tag/data widths and the empty encodings must match the rest of the core.
package cdb_arbiter_pkg;

  localparam int TAG_WIDTH      = 4;
  localparam int DATA_WIDTH     = 32;
  localparam int CDB_FIFO_DEPTH = 2;

  localparam logic [TAG_WIDTH-1:0]  EMPTY_TAG  = '0;
  localparam logic [DATA_WIDTH-1:0] EMPTY_DATA = '0;

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_LSB = 1'b1
  } grant_e;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer handshakes (ALU, LSB) and the broadcast side of the common data bus.
// The arbiter uses the slave modport; the producers/consumers environment uses master.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int TAG_W  = TAG_WIDTH,
  parameter int DATA_W = DATA_WIDTH
);

  logic              alu_valid;
  logic [TAG_W-1:0]  alu_tag;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              lsb_valid;
  logic [TAG_W-1:0]  lsb_tag;
  logic [DATA_W-1:0] lsb_data;
  logic              lsb_ready;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;

  modport slave (
    input  alu_valid, alu_tag, alu_data,
    input  lsb_valid, lsb_tag, lsb_data,
    output alu_ready, lsb_ready,
    output cdb_valid, cdb_tag, cdb_data
  );

  modport master (
    output alu_valid, alu_tag, alu_data,
    output lsb_valid, lsb_tag, lsb_data,
    input  alu_ready, lsb_ready,
    input  cdb_valid, cdb_tag, cdb_data
  );

endinterface

// File: rtl/cdb_arbiter_fifo.sv
// Small per-producer result queue: registered occupancy, naturally wrapping pointers,
// synchronous flush. Callers must never push when full.
module cdb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int               PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  // NOTE: only pointers and count need reset; stale storage is never read while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end
  end

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: queues ALU and LSB results, grants one per cycle round-robin
// on contention, and registers the winner onto the broadcast bus.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH  = CDB_FIFO_DEPTH,
  parameter int TAG_W  = TAG_WIDTH,
  parameter int DATA_W = DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          clear,
  cdb_arbiter_if.slave  bus
);

  localparam int                ENTRY_W   = TAG_W + DATA_W;
  localparam logic [TAG_W-1:0]  IDLE_TAG  = TAG_W'(EMPTY_TAG);
  localparam logic [DATA_W-1:0] IDLE_DATA = DATA_W'(EMPTY_DATA);

  logic               alu_push, alu_pop, alu_full, alu_empty;
  logic               lsb_push, lsb_pop, lsb_full, lsb_empty;
  logic [ENTRY_W-1:0] alu_head, lsb_head;

  grant_e             last_grant;
  logic               cdb_valid_q;
  logic [TAG_W-1:0]   cdb_tag_q;
  logic [DATA_W-1:0]  cdb_data_q;

  // Ready depends only on registered occupancy; a same-cycle pop never frees a slot.
  assign bus.alu_ready = !alu_full;
  assign bus.lsb_ready = !lsb_full;

  assign alu_push = rdy && bus.alu_valid && !alu_full && (bus.alu_tag != IDLE_TAG);
  assign lsb_push = rdy && bus.lsb_valid && !lsb_full && (bus.lsb_tag != IDLE_TAG);

  // A lone non-empty queue always wins; on contention the one not granted last wins.
  assign alu_pop = rdy && !alu_empty && (lsb_empty || last_grant == GRANT_LSB);
  assign lsb_pop = rdy && !lsb_empty && (alu_empty || last_grant == GRANT_ALU);

  cdb_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_alu_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (clear),
    .push  (alu_push),
    .pop   (alu_pop),
    .wdata ({bus.alu_tag, bus.alu_data}),
    .full  (alu_full),
    .empty (alu_empty),
    .head  (alu_head)
  );

  cdb_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_lsb_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (clear),
    .push  (lsb_push),
    .pop   (lsb_pop),
    .wdata ({bus.lsb_tag, bus.lsb_data}),
    .full  (lsb_full),
    .empty (lsb_empty),
    .head  (lsb_head)
  );

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= IDLE_TAG;
      cdb_data_q  <= IDLE_DATA;
      last_grant  <= GRANT_LSB;
    end else if (rdy) begin
      if (alu_pop) begin
        cdb_valid_q             <= 1'b1;
        {cdb_tag_q, cdb_data_q} <= alu_head;
      end else if (lsb_pop) begin
        cdb_valid_q             <= 1'b1;
        {cdb_tag_q, cdb_data_q} <= lsb_head;
      end else begin
        cdb_valid_q <= 1'b0;
        cdb_tag_q   <= IDLE_TAG;
        cdb_data_q  <= IDLE_DATA;
      end
      // Only a contended grant moves the round-robin pointer.
      if (alu_pop && !lsb_empty)      last_grant <= GRANT_ALU;
      else if (lsb_pop && !alu_empty) last_grant <= GRANT_LSB;
    end
  end

  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_tag   = cdb_tag_q;
  assign bus.cdb_data  = cdb_data_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: hand-computed broadcast sequences for single push,
// round-robin alternation, back-pressure, flush, freeze and empty-tag filtering.
module tb_cdb_arbiter;

  logic clk;
  logic rst;
  logic rdy;
  logic clear;

  int checks   = 0;
  int failures = 0;

  cdb_arbiter_if #(.TAG_W(4), .DATA_W(32)) bus ();

  cdb_arbiter #(.DEPTH(2), .TAG_W(4), .DATA_W(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, observed, expected);
    end
  endtask

  task automatic check_cdb(input string name, input logic v, input logic [3:0] tag, input logic [31:0] data);
    check({name, "_valid"}, {31'd0, bus.cdb_valid}, {31'd0, v});
    check({name, "_tag"},   {28'd0, bus.cdb_tag},   {28'd0, tag});
    check({name, "_data"},  bus.cdb_data,           data);
  endtask

  task automatic check_ready(input string name, input logic a, input logic l);
    check({name, "_alu_ready"}, {31'd0, bus.alu_ready}, {31'd0, a});
    check({name, "_lsb_ready"}, {31'd0, bus.lsb_ready}, {31'd0, l});
  endtask

  // Drive one cycle of producer inputs, clock once, and leave the bench 1 ns past the edge.
  task automatic step(input logic av, input logic [3:0] at, input logic [31:0] ad,
                      input logic lv, input logic [3:0] lt, input logic [31:0] ld);
    bus.alu_valid = av;
    bus.alu_tag   = at;
    bus.alu_data  = ad;
    bus.lsb_valid = lv;
    bus.lsb_tag   = lt;
    bus.lsb_data  = ld;
    if (!rst && !clear && rdy) begin
      if (av && at != 4'd0) check("alu_push_protocol", {31'd0, bus.alu_ready}, 32'd1);
      if (lv && lt != 4'd0) check("lsb_push_protocol", {31'd0, bus.lsb_ready}, 32'd1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
  endtask

  // Reset with valid inputs present; they must be dropped.
  task automatic do_reset(input string name);
    rst = 1'b1;
    step(1'b1, 4'd9, 32'h99, 1'b1, 4'd9, 32'h99);
    rst = 1'b0;
    check_cdb({name, "_rst"}, 1'b0, 4'd0, 32'd0);
    check_ready({name, "_rst"}, 1'b1, 1'b1);
    idle();
    check_cdb({name, "_rst_drop"}, 1'b0, 4'd0, 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    rdy   = 1'b1;
    clear = 1'b0;

    // Single ALU result: no bypass, one cycle of broadcast, then idle.
    do_reset("t1");
    step(1'b1, 4'd3, 32'h11, 1'b0, 4'd0, 32'd0);
    check_cdb("t1_no_bypass", 1'b0, 4'd0, 32'd0);
    idle();
    check_cdb("t1_bcast", 1'b1, 4'd3, 32'h11);
    idle();
    check_cdb("t1_idle", 1'b0, 4'd0, 32'd0);

    // Tie from reset goes to the ALU; the next tie goes to the LSB.
    do_reset("t2");
    step(1'b1, 4'd2, 32'hA, 1'b1, 4'd5, 32'hB);
    check_cdb("t2_no_bypass", 1'b0, 4'd0, 32'd0);
    idle();
    check_cdb("t2_first_alu", 1'b1, 4'd2, 32'hA);
    idle();
    check_cdb("t2_then_lsb", 1'b1, 4'd5, 32'hB);
    step(1'b1, 4'd6, 32'h66, 1'b1, 4'd7, 32'h77);
    check_cdb("t2_gap", 1'b0, 4'd0, 32'd0);
    idle();
    check_cdb("t2_second_lsb", 1'b1, 4'd7, 32'h77);
    idle();
    check_cdb("t2_second_alu", 1'b1, 4'd6, 32'h66);
    idle();
    check_cdb("t2_idle", 1'b0, 4'd0, 32'd0);

    // Back-pressure: LSB queue fills, ALU pushes whenever ready, grants alternate.
    do_reset("t3");
    step(1'b1, 4'd8, 32'h80, 1'b1, 4'd1, 32'h10);
    check_cdb("t3_e1", 1'b0, 4'd0, 32'd0);
    check_ready("t3_e1", 1'b1, 1'b1);
    step(1'b1, 4'd9, 32'h90, 1'b1, 4'd4, 32'h40);
    check_cdb("t3_e2", 1'b1, 4'd8, 32'h80);
    check_ready("t3_e2", 1'b1, 1'b0);
    step(1'b1, 4'd10, 32'hA0, 1'b0, 4'd0, 32'd0);
    check_cdb("t3_e3", 1'b1, 4'd1, 32'h10);
    check_ready("t3_e3", 1'b0, 1'b1);
    idle();
    check_cdb("t3_e4", 1'b1, 4'd9, 32'h90);
    check_ready("t3_e4", 1'b1, 1'b1);
    step(1'b1, 4'd11, 32'hB0, 1'b0, 4'd0, 32'd0);
    check_cdb("t3_e5", 1'b1, 4'd4, 32'h40);
    check_ready("t3_e5", 1'b0, 1'b1);
    idle();
    check_cdb("t3_e6", 1'b1, 4'd10, 32'hA0);
    idle();
    check_cdb("t3_e7", 1'b1, 4'd11, 32'hB0);
    idle();
    check_cdb("t3_e8", 1'b0, 4'd0, 32'd0);

    // Flush with pending entries and new inputs: nothing stale ever appears.
    do_reset("t4");
    step(1'b1, 4'd1, 32'h1, 1'b1, 4'd2, 32'h2);
    step(1'b1, 4'd3, 32'h3, 1'b1, 4'd4, 32'h4);
    check_cdb("t4_e2", 1'b1, 4'd1, 32'h1);
    step(1'b1, 4'd5, 32'h5, 1'b0, 4'd0, 32'd0);
    check_cdb("t4_e3", 1'b1, 4'd2, 32'h2);
    check_ready("t4_e3", 1'b0, 1'b1);
    clear = 1'b1;
    step(1'b1, 4'd6, 32'h6, 1'b1, 4'd9, 32'h9);
    clear = 1'b0;
    check_cdb("t4_clear", 1'b0, 4'd0, 32'd0);
    check_ready("t4_clear", 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idle();
      check_cdb("t4_post_clear", 1'b0, 4'd0, 32'd0);
    end
    step(1'b1, 4'd10, 32'hA, 1'b1, 4'd11, 32'hB);
    idle();
    check_cdb("t4_tie_alu", 1'b1, 4'd10, 32'hA);
    idle();
    check_cdb("t4_tie_lsb", 1'b1, 4'd11, 32'hB);

    // Freeze for three cycles with valid inputs; resume matches the unfrozen order.
    do_reset("t5");
    step(1'b1, 4'd1, 32'h1, 1'b1, 4'd2, 32'h2);
    check_cdb("t5_e1", 1'b0, 4'd0, 32'd0);
    step(1'b1, 4'd3, 32'h3, 1'b0, 4'd0, 32'd0);
    check_cdb("t5_e2", 1'b1, 4'd1, 32'h1);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'd7, 32'h7, 1'b1, 4'd8, 32'h8);
      check_cdb("t5_frozen", 1'b1, 4'd1, 32'h1);
      check_ready("t5_frozen", 1'b1, 1'b1);
    end
    rdy = 1'b1;
    idle();
    check_cdb("t5_resume_lsb", 1'b1, 4'd2, 32'h2);
    idle();
    check_cdb("t5_resume_alu", 1'b1, 4'd3, 32'h3);
    idle();
    check_cdb("t5_drained", 1'b0, 4'd0, 32'd0);

    // Empty tag is ignored and does not consume a slot.
    do_reset("t6");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'd0, 32'h55, 1'b0, 4'd0, 32'd0);
      check_cdb("t6_tag0", 1'b0, 4'd0, 32'd0);
      check_ready("t6_tag0", 1'b1, 1'b1);
    end
    step(1'b1, 4'd12, 32'hC, 1'b0, 4'd0, 32'd0);
    check_cdb("t6_after_push", 1'b0, 4'd0, 32'd0);
    idle();
    check_cdb("t6_real", 1'b1, 4'd12, 32'hC);
    idle();
    check_cdb("t6_no_phantom", 1'b0, 4'd0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
